// File: rtl/mult_sched.sv
// mult_sched: collects DEPTH operand pairs from one of two requesters into an
// external block multiplier, then reads the DEPTH results back and returns
// them to the requester that owned the batch. Grants rotate per batch.
//
// Handshake: an operand pair moves on a rising edge where reqN_valid and
// reqN_ready are both high. Ready depends only on valid, mult_rdy and the
// current owner/state, never on the next pair. Results are one-cycle pulses
// on resN_valid with no back-pressure; res_last marks the final beat.
module mult_sched #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req1_valid,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             res0_valid,
  output logic             res1_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic             mult_en,
  input  logic             mult_rdy,
  output logic [15:0]      mult_in0,
  output logic [15:0]      mult_in1,
  output logic             mult_blockread,
  input  logic             mult_valid,
  input  logic [WIDTH-1:0] mult_data,
  output logic             owner,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state_dbg
);

  localparam int CW = LOGDEPTH + 1;
  localparam logic [CW-1:0] DEPTH_M1 = CW'((1 << LOGDEPTH) - 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_WAITFULL = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state;
  logic          last_served;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] drain_cnt;
  logic [WW-1:0] wd_cnt;
  logic          got_beat;

  logic owner_valid;
  logic accept;
  logic beat;
  logic rdy_fall;
  logic wd_active;
  logic progress;
  logic timeout;
  logic grant;

  assign state_dbg = state;
  assign busy      = (state != S_IDLE);

  // Owner-side issue path, watchdog qualifiers and the idle-time arbiter.
  always_comb begin
    owner_valid    = owner ? req1_valid : req0_valid;
    accept         = (state == S_FILL) && owner_valid && mult_rdy;
    req0_ready     = accept && !owner;
    req1_ready     = accept && owner;
    mult_en        = accept;
    mult_in0       = '0;
    mult_in1       = '0;
    if (state == S_FILL) begin
      mult_in0 = owner ? req1_a : req0_a;
      mult_in1 = owner ? req1_b : req0_b;
    end
    mult_blockread = (state == S_DRAIN) && !got_beat;
    beat           = (state == S_DRAIN) && mult_valid;
    rdy_fall       = (state == S_WAITFULL) && !mult_rdy;
    // A stalled owner (valid low) is not a hang, so FILL only counts while valid.
    wd_active      = ((state == S_FILL) && owner_valid) ||
                     (state == S_WAITFULL) || (state == S_DRAIN);
    progress       = accept || rdy_fall || beat;
    timeout        = wd_active && !progress && (wd_cnt == WD_LIMIT);
    // Tie goes to whoever did not own the last completed batch.
    grant          = (req0_valid && req1_valid) ? ~last_served : req1_valid;
  end

  // Batch FSM, counters, result register and watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      issue_cnt   <= '0;
      drain_cnt   <= '0;
      wd_cnt      <= '0;
      got_beat    <= 1'b0;
      err         <= 1'b0;
      res0_valid  <= 1'b0;
      res1_valid  <= 1'b0;
      res_last    <= 1'b0;
      res_data    <= '0;
    end else begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      res_last   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            owner <= grant;
            state <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt == DEPTH_M1) state <= S_WAITFULL;
          end
        end
        S_WAITFULL: begin
          if (!mult_rdy) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (mult_valid) begin
            got_beat   <= 1'b1;
            res_data   <= mult_data;
            res0_valid <= !owner;
            res1_valid <= owner;
            drain_cnt  <= drain_cnt + 1'b1;
            if (drain_cnt == DEPTH_M1) begin
              res_last <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          last_served <= owner;
          issue_cnt   <= '0;
          drain_cnt   <= '0;
          got_beat    <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Timeout never coincides with progress, so it cannot collide with a
      // state move above; it simply abandons the batch.
      if (timeout) begin
        err       <= 1'b1;
        state     <= S_IDLE;
        issue_cnt <= '0;
        drain_cnt <= '0;
        got_beat  <= 1'b0;
        wd_cnt    <= '0;
      end else if (progress) begin
        wd_cnt <= '0;
      end else if (wd_active) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else if (state != S_FILL) begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter LOGDEPTH, default 6, meaning log2 of results per batch (DEPTH = 2^LOGDEPTH).
REQ-002 SHALL have parameter WIDTH, default 32, meaning result width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning no-progress watchdog limit in cycles.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- req0_valid / req1_valid, in, 1, requester operand valid.
- req0_a, req0_b, req1_a, req1_b, in, 16 each, requester operands.
- req0_ready / req1_ready, out, 1, operand accepted this cycle.
- res0_valid / res1_valid, out, 1, result beat for requester 0 / 1.
- res_data, out, WIDTH, result beat data, shared.
- res_last, out, 1, final beat of a batch.
- mult_en, out, 1, to multiplier EN_mult.
- mult_rdy, in, 1, from multiplier RDY_mult.
- mult_in0 / mult_in1, out, 16 each, multiplier operands.
- mult_blockread, out, 1, to multiplier EN_blockRead.
- mult_valid, in, 1, from multiplier VALID_memVal.
- mult_data, in, WIDTH, from multiplier memVal_data.
- owner, out, 1, requester granted the current batch.
- busy, out, 1, high in any state but IDLE.
- err, out, 1, sticky watchdog error.

Function
REQ-005 SHALL implement states IDLE, FILL, WAITFULL, DRAIN, DONE.
REQ-006 In IDLE, arbitration SHALL be round-robin at batch granularity.
- One valid requester: grant it.
- Both valid: grant the requester not served by the last completed batch.
- Set owner and move to FILL on the next edge.
REQ-007 In FILL, req<owner>_ready SHALL equal req<owner>_valid AND mult_rdy; the non-owner ready SHALL be 0.
REQ-008 mult_en SHALL equal the owner's accept condition; mult_in0/mult_in1 SHALL be the owner's a/b combinationally, with zero added latency.
REQ-009 An issue counter SHALL increment per accepted pair; after DEPTH accepts, move to WAITFULL.
REQ-010 If the owner's valid drops mid-batch, the block SHALL stall with no issue; the other requester SHALL NOT be granted.
REQ-011 In WAITFULL, mult_en SHALL be 0; when mult_rdy is 0, move to DRAIN.
REQ-012 In DRAIN, mult_blockread SHALL be held at 1 until the first mult_valid beat, then 0.
REQ-013 Each mult_valid beat SHALL register mult_data to res_data and assert res<owner>_valid one cycle later; the non-owner valid SHALL stay 0.
REQ-014 A drain counter SHALL count beats; on beat DEPTH, res_last SHALL assert with that beat and the state SHALL move to DONE.
REQ-015 mult_valid beats beyond DEPTH SHALL be ignored.
REQ-016 DONE SHALL last one cycle.
- Record owner as last-served.
- Clear both counters.
- Return to IDLE.
REQ-017 Watchdog: in FILL (only while owner valid is high), WAITFULL and DRAIN, a counter SHALL count cycles without progress.
- Progress is an accept, the mult_rdy fall, or a beat.
- The counter resets on progress.
- Reaching TIMEOUT SHALL set err and force IDLE, with counters cleared.
REQ-018 err SHALL clear only on reset.
REQ-019 Counters SHALL be LOGDEPTH+1 bits wide, with no wrap within a batch.
REQ-020 Requests arriving during a batch SHALL wait; ready stays 0 until granted.

Reset
REQ-021 On rst low, asynchronously:
- State SHALL go to IDLE and all counters SHALL clear.
- last-served SHALL become 1, so requester 0 wins the first tie.
- All outputs SHALL be 0: ready, res valid, res_data, res_last, mult_en, mult_in0/1, mult_blockread, owner, busy, err.
REQ-022 Reset mid-batch SHALL abandon the batch; no res beat SHALL appear after rst deasserts until a new batch drains.
REQ-023 Reset release SHALL take effect at the first rising clk edge after rst goes high.

Verification
REQ-024 Both requesters valid from reset, mult_rdy=1 -> owner=0, 64 mult_en pulses from req0; after mult_rdy falls, blockread, 64 res0_valid beats, res_last on the 64th; next batch owner=1.
REQ-025 Only req1 valid, with a=16'h0003, b=16'h0005 -> mult_in0=3, mult_in1=5 on the issue cycles; req0_ready stays 0 throughout.
REQ-026 req0 valid drops after 10 accepts for 20 cycles, req1 valid -> no grant to req1 and mult_en=0 during the gap; the batch resumes at count 10 and totals 64.
REQ-027 mult_rdy held 1 in WAITFULL for TIMEOUT=16 cycles -> err=1 and busy=0 at cycle 16; err stays 1 through subsequent batches.
REQ-028 rst low at beat 30 of DRAIN -> all outputs 0 immediately; after release, no res beats, state IDLE, owner=0.
REQ-029 70 mult_valid beats presented -> exactly 64 res beats, res_last once.
